colour_frame_classifier: RTL and testbench
==========================================

Name: colour_frame_classifier

Overview:
- N-channel successor to the per-colour pixel detectors in the camera path.
- Classifies each streamed pixel against all colour channels in parallel and accumulates per-channel counts over a frame bounded by sop/eop.
- On eop, snapshots the counts and runs a sequential argmax scan.
- Publishes a dominant colour to the direction FSM only after it has been stable for QUAL_FRAMES consecutive frames.

Parameters:
- CHANNELS, 3: number of colour components per pixel; channel 0 occupies the MSBs.
- COMP_BITS, 4: bits per component; pixel width is CHANNELS*COMP_BITS.
- COUNT_WIDTH, 17: per-channel frame counter width.
- QUAL_FRAMES, 2: consecutive identical frame results required before `dominant` changes (minimum 1).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- pix_valid  in  1  pixel qualifier; all pixel-side inputs are ignored when low.
- pix_data  in  CHANNELS*COMP_BITS  packed pixel; channel c is at bits [(CHANNELS-c)*COMP_BITS-1 -: COMP_BITS].
- sop  in  1  start of frame, qualified by pix_valid.
- eop  in  1  end of frame, qualified by pix_valid.
- thresh_hi  in  COMP_BITS  minimum component value for a match.
- margin  in  COMP_BITS  required lead of the matching component over every other component.
- count_threshold  in  COUNT_WIDTH  minimum count for a channel to be a dominant candidate.
- pix_mask  out  CHANNELS  registered per-channel match of the last valid pixel.
- frame_counts  out  CHANNELS*COUNT_WIDTH  snapshot of the last completed frame; channel 0 in the MSBs.
- counts_valid  out  1  one-cycle pulse when frame_counts updates.
- count_sat  out  CHANNELS  per-channel saturation flag for the snapshot frame.
- dominant  out  $clog2(CHANNELS+1)  qualified dominant channel; the value CHANNELS means none.
- dominant_change  out  1  one-cycle pulse when dominant changes.
- frame_dropped  out  1  one-cycle pulse on a discarded frame.

Behaviour:
- Reset (async, any state):
  - All outputs are 0, except dominant = CHANNELS.
  - Accumulators cleared, streak = 0, pending = CHANNELS, FSM = IDLE.
- Classification (combinational, on the current pixel):
  - match[c] = (comp[c] >= thresh_hi) AND, for all k≠c, (comp[c] >= comp[k] + margin).
  - The addition is evaluated at COMP_BITS+1 bits, so it cannot wrap.
  - More than one bit may be set, e.g. when margin = 0 and components are equal.
  - pix_mask registers match on every valid pixel.
- Accumulator FSM:
  - IDLE → ACCUM on valid sop. Accumulators load match, so the sop pixel is counted.
  - ACCUM:
    - Each valid pixel adds match[c] to acc[c].
    - Counters saturate at all-ones and set a sticky sat[c].
    - Valid sop in ACCUM restarts the frame: accumulators reload match and sat clears. No pulse is generated.
    - Valid eop: the final values including the eop pixel are copied to frame_counts/count_sat at cycle T+1 with counts_valid high. FSM → IDLE. Scan starts.
  - sop and eop on the same valid pixel:
    - Treated as a one-pixel frame: restart followed by immediate eop.
  - Valid eop in IDLE:
    - Pulses frame_dropped at T+1. No snapshot, no scan.
- Scan, independent of the accumulator FSM:
  - Runs CHANNELS cycles, T+1..T+CHANNELS, over frame_counts, index 0 upward.
  - candidate = channel with the largest count that is >= count_threshold.
  - Ties resolve to the lowest index. If no channel qualifies, candidate = CHANNELS.
  - The accumulator may start a new frame during the scan; the snapshot is stable.
  - An eop arriving while the scan is busy is not snapshotted: frame_dropped pulses and the old snapshot is kept.
- Qualification, at T+CHANNELS+1:
  - If candidate == pending, streak increments, saturating at QUAL_FRAMES. Otherwise pending = candidate and streak = 1.
  - When streak == QUAL_FRAMES and pending ≠ dominant: dominant = pending and dominant_change pulses in the same cycle.
- Latency:
  - counts_valid at eop+1.
  - dominant/dominant_change at eop+CHANNELS+1.
- Reset mid-frame or mid-scan discards all partial state; no pulses are emitted.

Test Plan (defaults, thresh_hi=8, margin=4, count_threshold=5):
- Frame of 10 pixels: 6×0xF00, 4×0x000 → frame_counts = {6,0,0}, counts_valid at eop+1. After frame 1, dominant stays 3. Frame 2 identical → dominant = 0 at eop+4 with a dominant_change pulse.
- Pixel 0x880 with margin=0 → pix_mask = 3'b110. The same pixel with margin=1 → 3'b000.
- Frame of 5×0xF00 then 5×0x0F0 → counts {5,5,0}; candidate resolves to 0 (tie → lowest index). A frame with 4×0xF00 only → candidate = 3 (none).
- Override COUNT_WIDTH=4; 20×0x00F in one frame → blue count = 15, count_sat = 3'b001.
- eop without a preceding sop → frame_dropped pulse, no counts_valid. A second frame whose eop lands one cycle after the first eop → frame_dropped, and the first snapshot is retained.
- Assert reset mid-ACCUM after a qualified dominant=0 → dominant = 3, frame_counts = 0 immediately. The next sop frame counts from zero.

Source files
------------

// File: rtl/colour_frame_classifier.sv
// Streams packed N-channel pixels, flags per-channel colour matches, counts them per frame,
// then scans the frame snapshot for the dominant channel and publishes it once stable.
module colour_frame_classifier #(
  parameter int CHANNELS    = 3,
  parameter int COMP_BITS   = 4,
  parameter int COUNT_WIDTH = 17,
  parameter int QUAL_FRAMES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            pix_valid,
  input  logic [CHANNELS*COMP_BITS-1:0]   pix_data,
  input  logic                            sop,
  input  logic                            eop,
  input  logic [COMP_BITS-1:0]            thresh_hi,
  input  logic [COMP_BITS-1:0]            margin,
  input  logic [COUNT_WIDTH-1:0]          count_threshold,
  output logic [CHANNELS-1:0]             pix_mask,
  output logic [CHANNELS*COUNT_WIDTH-1:0] frame_counts,
  output logic                            counts_valid,
  output logic [CHANNELS-1:0]             count_sat,
  output logic [$clog2(CHANNELS+1)-1:0]   dominant,
  output logic                            dominant_change,
  output logic                            frame_dropped
);
  localparam int DW = $clog2(CHANNELS + 1);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int QF = (QUAL_FRAMES < 1) ? 1 : QUAL_FRAMES;
  localparam int SW = $clog2(QF + 1);
  localparam logic [DW-1:0] NONE = DW'(CHANNELS);
  localparam logic [SW-1:0] QMAX = SW'(QF);
  localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  // Returns {overflow, next}; the counter sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH:0] sat_inc(input logic [COUNT_WIDTH-1:0] v,
                                                   input logic inc);
    if (inc && (&v)) return {1'b1, v};
    return {1'b0, v + COUNT_WIDTH'(inc)};
  endfunction

  logic [COMP_BITS-1:0]   comp [CHANNELS];
  logic [CHANNELS-1:0]    match;
  logic [COUNT_WIDTH-1:0] acc_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] acc_d [CHANNELS];
  logic [COUNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [CHANNELS-1:0]    sat_q, sat_d, snap_sat_q, mask_q;
  logic [COUNT_WIDTH:0]   inc_r;
  state_t                 state_q;
  logic                   cv_q, fd_q, dchg_q;
  logic                   px_sop, px_eop, live, snap, drop;

  logic                   busy_q;
  logic [IW-1:0]          idx_q;
  logic [DW-1:0]          best_idx_q, cand_d, pending_q, pend_d, dom_q;
  logic [COUNT_WIDTH-1:0] best_cnt_q, cand_cnt_d;
  logic [SW-1:0]          streak_q, streak_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign comp[g] = pix_data[(CHANNELS-g)*COMP_BITS-1 -: COMP_BITS];
    assign frame_counts[(CHANNELS-g)*COUNT_WIDTH-1 -: COUNT_WIDTH] = cnt_q[g];
  end

  // Channel c sits at bit CHANNELS-1-c of every per-channel vector (channel 0 in the MSB).
  always_comb begin
    match = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      match[CHANNELS-1-c] = (comp[c] >= thresh_hi);
      for (int k = 0; k < CHANNELS; k++) begin
        if ((k != c) && ({1'b0, comp[c]} < ({1'b0, comp[k]} + {1'b0, margin})))
          match[CHANNELS-1-c] = 1'b0;
      end
    end
  end

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    inc_r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sop) begin
        acc_d[c]            = COUNT_WIDTH'(match[CHANNELS-1-c]);
        sat_d[CHANNELS-1-c] = 1'b0;
      end else begin
        inc_r               = sat_inc(acc_q[c], match[CHANNELS-1-c]);
        acc_d[c]            = inc_r[COUNT_WIDTH-1:0];
        sat_d[CHANNELS-1-c] = sat_q[CHANNELS-1-c] | inc_r[COUNT_WIDTH];
      end
    end
  end

  assign px_sop = pix_valid & sop;
  assign px_eop = pix_valid & eop;
  assign live   = px_sop | (pix_valid & (state_q == ACCUM));
  assign snap   = px_eop & live & ~busy_q;
  assign drop   = px_eop & (~live | busy_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      sat_q      <= '0;
      snap_sat_q <= '0;
      cv_q       <= 1'b0;
      fd_q       <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      cv_q <= snap;
      fd_q <= drop;
      if (pix_valid) mask_q <= match;
      if (live) begin
        acc_q <= acc_d;
        sat_q <= sat_d;
      end
      if (px_sop) state_q <= ACCUM;
      if (px_eop) state_q <= IDLE;
      if (snap) begin
        cnt_q      <= acc_d;
        snap_sat_q <= sat_d;
      end
    end
  end

  // Scan step: fold one snapshot channel per cycle into the running best; qualify on the last.
  always_comb begin
    cand_d     = best_idx_q;
    cand_cnt_d = best_cnt_q;
    if ((cnt_q[idx_q] >= count_threshold) &&
        ((best_idx_q == NONE) || (cnt_q[idx_q] > best_cnt_q))) begin
      cand_d     = DW'(idx_q);
      cand_cnt_d = cnt_q[idx_q];
    end
    if (cand_d == pending_q) begin
      pend_d   = pending_q;
      streak_d = (streak_q == QMAX) ? QMAX : streak_q + 1'b1;
    end else begin
      pend_d   = cand_d;
      streak_d = SW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= 1'b0;
      idx_q      <= '0;
      best_idx_q <= NONE;
      best_cnt_q <= '0;
      pending_q  <= NONE;
      streak_q   <= '0;
      dom_q      <= NONE;
      dchg_q     <= 1'b0;
    end else begin
      dchg_q <= 1'b0;
      if (snap) begin
        busy_q     <= 1'b1;
        idx_q      <= '0;
        best_idx_q <= NONE;
        best_cnt_q <= '0;
      end else if (busy_q) begin
        best_idx_q <= cand_d;
        best_cnt_q <= cand_cnt_d;
        if (idx_q == LAST) begin
          busy_q    <= 1'b0;
          pending_q <= pend_d;
          streak_q  <= streak_d;
          if ((streak_d == QMAX) && (pend_d != dom_q)) begin
            dom_q  <= pend_d;
            dchg_q <= 1'b1;
          end
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign pix_mask        = mask_q;
  assign counts_valid    = cv_q;
  assign count_sat       = snap_sat_q;
  assign dominant        = dom_q;
  assign dominant_change = dchg_q;
  assign frame_dropped   = fd_q;
endmodule

// File: tb/tb_colour_frame_classifier.sv
// Bench for colour_frame_classifier: classification table, directed frame sequences,
// and a randomized stream compared against a frame-level reference model.
module tb_colour_frame_classifier;
  localparam int CH = 3, CB = 4, CW = 17, CW4 = 4, QF = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, reset = 1'b1;
  logic pix_valid = 1'b0, sop = 1'b0, eop = 1'b0;
  logic [CH*CB-1:0] pix_data = '0;
  logic [CB-1:0] thresh_hi = 4'd8, margin = 4'd4;
  logic [CW-1:0] count_threshold = 17'd5;
  logic [CW4-1:0] count_threshold4 = 4'd5;

  logic [CH-1:0] pix_mask, count_sat, pix_mask4, count_sat4;
  logic [CH*CW-1:0] frame_counts;
  logic [CH*CW4-1:0] frame_counts4;
  logic [1:0] dominant, dominant4;
  logic counts_valid, dominant_change, frame_dropped;
  logic counts_valid4, dominant_change4, frame_dropped4;

  colour_frame_classifier dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data), .sop(sop), .eop(eop),
    .thresh_hi(thresh_hi), .margin(margin), .count_threshold(count_threshold),
    .pix_mask(pix_mask), .frame_counts(frame_counts), .counts_valid(counts_valid),
    .count_sat(count_sat), .dominant(dominant), .dominant_change(dominant_change),
    .frame_dropped(frame_dropped));

  colour_frame_classifier #(.COUNT_WIDTH(CW4)) dut4 (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data), .sop(sop), .eop(eop),
    .thresh_hi(thresh_hi), .margin(margin), .count_threshold(count_threshold4),
    .pix_mask(pix_mask4), .frame_counts(frame_counts4), .counts_valid(counts_valid4),
    .count_sat(count_sat4), .dominant(dominant4), .dominant_change(dominant_change4),
    .frame_dropped(frame_dropped4));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [11:0] d, input logic s, input logic e);
    pix_valid = 1'b1; pix_data = d; sop = s; eop = e;
    tick();
    pix_valid = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  task automatic gap(input logic [11:0] d);
    pix_valid = 1'b0; pix_data = d; sop = 1'b1; eop = 1'b1;
    tick();
    sop = 1'b0; eop = 1'b0;
  endtask

  task automatic send(input logic [11:0] d, input int n, input logic s_first, input logic e_last);
    for (int i = 0; i < n; i++) pix(d, s_first && (i == 0), e_last && (i == n - 1));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    pix_valid = 1'b0; sop = 1'b0; eop = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  function automatic logic [CH*CW-1:0] fc3(input int a, input int b, input int c);
    return {CW'(a), CW'(b), CW'(c)};
  endfunction

  typedef struct packed {
    logic [11:0] pix;
    logic [3:0]  th;
    logic [3:0]  mg;
    logic [2:0]  mask;
  } cls_vec_t;
  cls_vec_t tbl [13];

  // Reference model: plain integer frame bookkeeping driven by cycle numbers.
  int m_acc [CH];
  bit m_sat [CH];
  int m_snap [CH];
  bit m_ssat [CH];
  bit m_in;
  int m_scan_end, m_res_at, m_cand, m_pend, m_streak, m_dom, cyc, cthr, mg;
  logic [CH-1:0] m_mask, mt, es;
  logic [CH*CW-1:0] efc;
  logic [10:0] exp_v, act_v;
  bit rv, rs, re, exp_cv, exp_fd, exp_dc;
  logic [11:0] rd;

  function automatic logic [CH-1:0] ref_match(input logic [11:0] d, input int th, input int m);
    int v [CH];
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) v[c] = (int'(d) >> ((CH - 1 - c) * CB)) & 15;
    for (int c = 0; c < CH; c++) begin
      r[CH-1-c] = (v[c] >= th);
      for (int k = 0; k < CH; k++)
        if (k != c && v[c] < v[k] + m) r[CH-1-c] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [3:0] pick();
    logic [3:0] vals [7];
    vals = '{4'd0, 4'd2, 4'd5, 4'd8, 4'd10, 4'd12, 4'd15};
    return vals[$urandom_range(0, 6)];
  endfunction

  initial begin
    tbl[0]  = '{12'h880, 4'd8, 4'd0, 3'b110};
    tbl[1]  = '{12'h880, 4'd8, 4'd1, 3'b000};
    tbl[2]  = '{12'hF00, 4'd8, 4'd4, 3'b100};
    tbl[3]  = '{12'h0F0, 4'd8, 4'd4, 3'b010};
    tbl[4]  = '{12'h00F, 4'd8, 4'd4, 3'b001};
    tbl[5]  = '{12'h000, 4'd8, 4'd4, 3'b000};
    tbl[6]  = '{12'hFB0, 4'd8, 4'd4, 3'b100};
    tbl[7]  = '{12'hFC0, 4'd8, 4'd4, 3'b000};
    tbl[8]  = '{12'h800, 4'd8, 4'd4, 3'b100};
    tbl[9]  = '{12'h700, 4'd8, 4'd4, 3'b000};
    tbl[10] = '{12'h888, 4'd8, 4'd0, 3'b111};
    tbl[11] = '{12'hF4F, 4'd8, 4'd0, 3'b101};
    tbl[12] = '{12'h000, 4'd0, 4'd0, 3'b111};

    idle(2);
    check("rst_mask", pix_mask, 0);
    check("rst_counts", frame_counts, 0);
    check("rst_cv", counts_valid, 0);
    check("rst_sat", count_sat, 0);
    check("rst_dom", dominant, 3);
    check("rst_dchg", dominant_change, 0);
    check("rst_drop", frame_dropped, 0);
    reset = 1'b0;

    send(12'hF00, 6, 1, 0);
    send(12'h000, 4, 0, 1);
    check("f1_cv", counts_valid, 1);
    check("f1_counts", frame_counts, fc3(6, 0, 0));
    tick();
    check("f1_cv_pulse", counts_valid, 0);
    idle(2);
    check("f1_dom_held", dominant, 3);
    check("f1_dchg", dominant_change, 0);
    send(12'hF00, 6, 1, 0);
    send(12'h000, 4, 0, 1);
    idle(2);
    check("f2_dom_early", dominant, 3);
    tick();
    check("f2_dom", dominant, 0);
    check("f2_dchg", dominant_change, 1);
    tick();
    check("f2_dchg_pulse", dominant_change, 0);

    pix(12'hF00, 1, 0); pix(12'hF00, 0, 0); pix(12'hF00, 0, 0);
    pix(12'h0F0, 1, 0);
    send(12'h0F0, 4, 0, 0);
    pix(12'h0F0, 0, 1);
    check("restart_counts", frame_counts, fc3(0, 6, 0));
    idle(4);
    pix(12'hF00, 1, 0); gap(12'hF00); gap(12'hF00);
    send(12'hF00, 2, 0, 0);
    pix(12'h000, 0, 1);
    check("gap_counts", frame_counts, fc3(3, 0, 0));
    check("gap_cv", counts_valid, 1);
    idle(4);

    do_reset();
    foreach (tbl[i]) begin
      thresh_hi = tbl[i].th;
      margin = tbl[i].mg;
      pix(tbl[i].pix, 0, 0);
      check($sformatf("cls_%0d", i), pix_mask, tbl[i].mask);
    end
    pix_data = 12'hF00;
    tick();
    check("mask_hold", pix_mask, 3'b111);
    check("no_frame_cv", counts_valid, 0);
    thresh_hi = 4'd8; margin = 4'd4;

    do_reset();
    for (int f = 0; f < 2; f++) begin
      send(12'hF00, 5, 1, 0);
      send(12'h0F0, 5, 0, 1);
      idle(3);
    end
    check("tie_counts", frame_counts, fc3(5, 5, 0));
    check("tie_dom", dominant, 0);
    check("tie_dchg", dominant_change, 1);
    idle(1);
    for (int f = 0; f < 2; f++) begin
      send(12'hF00, 4, 1, 0);
      send(12'h000, 6, 0, 1);
      idle(3);
    end
    check("none_dom", dominant, 3);
    check("none_dchg", dominant_change, 1);
    idle(1);

    send(12'h00F, 20, 1, 1);
    check("sat4_counts", frame_counts4, {4'd0, 4'd0, 4'd15});
    check("sat4_flag", count_sat4, 3'b001);
    check("sat4_cv", counts_valid4, 1);
    check("wide_counts", frame_counts, fc3(0, 0, 20));
    check("wide_sat", count_sat, 3'b000);
    idle(5);

    pix(12'h000, 0, 1);
    check("orphan_drop", frame_dropped, 1);
    check("orphan_cv", counts_valid, 0);
    tick();
    check("orphan_drop_pulse", frame_dropped, 0);
    send(12'hF00, 6, 1, 0);
    pix(12'h000, 0, 1);
    check("busy_first_cv", counts_valid, 1);
    pix(12'h00F, 1, 1);
    check("busy_t1_drop", frame_dropped, 1);
    check("busy_t1_cv", counts_valid, 0);
    idle(1);
    pix(12'h0F0, 1, 1);
    check("busy_t3_drop", frame_dropped, 1);
    check("busy_t3_kept", frame_counts, fc3(6, 0, 0));
    pix(12'h0F0, 1, 1);
    check("free_t4_cv", counts_valid, 1);
    check("free_t4_drop", frame_dropped, 0);
    check("free_t4_counts", frame_counts, fc3(0, 1, 0));
    idle(4);

    do_reset();
    for (int f = 0; f < 2; f++) begin
      send(12'hF00, 6, 1, 0);
      send(12'h000, 4, 0, 1);
      idle(4);
    end
    check("pre_rst_dom", dominant, 0);
    send(12'hF00, 3, 1, 0);
    #2 reset = 1'b1;
    #1;
    check("async_dom", dominant, 3);
    check("async_counts", frame_counts, 0);
    check("async_mask", pix_mask, 0);
    tick();
    reset = 1'b0;
    send(12'hF00, 6, 1, 0);
    send(12'h000, 4, 0, 1);
    check("post_rst_counts", frame_counts, fc3(6, 0, 0));
    idle(3);
    check("post_rst_dom", dominant, 3);
    check("post_rst_dchg", dominant_change, 0);

    cthr = 3;
    mg = $urandom_range(0, 4);
    count_threshold = CW'(cthr);
    margin = CB'(mg);
    thresh_hi = 4'd8;
    do_reset();
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0; m_sat[c] = 0; m_snap[c] = 0; m_ssat[c] = 0;
    end
    m_in = 0; m_scan_end = -100; m_res_at = -1; m_cand = CH;
    m_pend = CH; m_streak = 0; m_dom = CH; m_mask = '0; cyc = 0;
    for (int t = 0; t < 2500; t++) begin
      rv = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 15) == 0);
      re = ($urandom_range(0, 9) == 0);
      rd = {pick(), pick(), pick()};
      pix_valid = rv; pix_data = rd; sop = rs; eop = re;
      exp_cv = 0; exp_fd = 0; exp_dc = 0;
      if (m_res_at == cyc) begin
        if (m_cand == m_pend) m_streak = (m_streak < QF) ? m_streak + 1 : QF;
        else begin m_pend = m_cand; m_streak = 1; end
        if (m_streak == QF && m_pend != m_dom) begin m_dom = m_pend; exp_dc = 1; end
      end
      if (rv) begin
        mt = ref_match(rd, 8, mg);
        m_mask = mt;
        if (rs) begin
          for (int c = 0; c < CH; c++) begin m_acc[c] = int'(mt[CH-1-c]); m_sat[c] = 0; end
          m_in = 1;
        end else if (m_in) begin
          for (int c = 0; c < CH; c++)
            if (mt[CH-1-c]) begin
              if (m_acc[c] == CMAX) m_sat[c] = 1;
              else m_acc[c]++;
            end
        end
        if (re) begin
          if (m_in && cyc > m_scan_end) begin
            m_snap = m_acc; m_ssat = m_sat; exp_cv = 1;
            m_scan_end = cyc + CH; m_res_at = cyc + CH;
            m_cand = CH;
            for (int c = 0; c < CH; c++)
              if (m_snap[c] >= cthr && (m_cand == CH || m_snap[c] > m_snap[m_cand])) m_cand = c;
          end else exp_fd = 1;
          m_in = 0;
        end
      end
      tick();
      cyc++;
      for (int c = 0; c < CH; c++) begin
        efc[(CH-c)*CW-1 -: CW] = CW'(m_snap[c]);
        es[CH-1-c] = m_ssat[c];
      end
      exp_v = {m_mask, exp_cv, es, 2'(m_dom), exp_dc, exp_fd};
      act_v = {pix_mask, counts_valid, count_sat, dominant, dominant_change, frame_dropped};
      check($sformatf("rand_ctrl_%0d", t), act_v, exp_v);
      check($sformatf("rand_counts_%0d", t), frame_counts, efc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
